// File: rtl/game_sequencer_if.sv
// game_sequencer_if: play-control inputs and game status outputs of game_sequencer
interface game_sequencer_if;
  logic        frame;
  logic        start;
  logic        pause;
  logic        hit;
  logic [3:0]  state;
  logic        run;
  logic [3:0]  speed;
  logic        clr;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        blink;
  modport master (output frame, start, pause, hit, input state, run, speed, clr, score, hiscore, blink);
  modport slave  (input frame, start, pause, hit, output state, run, speed, clr, score, hiscore, blink);
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game state machine with BCD score, high score, speed and blink control
module game_sequencer #(
  parameter int COUNT_FRAMES = 180,
  parameter int SCORE_DIV    = 6,
  parameter int HIT_FRAMES   = 60,
  parameter int SPEED_INIT   = 1,
  parameter int SPEED_MAX    = 8,
  parameter int FLASH_DIV    = 16
) (
  input logic board_clk,
  input logic Reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [3:0] {IDLE = 4'd0, COUNT = 4'd1, PLAY = 4'd2, PAUSE = 4'd3, HIT = 4'd4, OVER = 4'd5} state_t;
  localparam logic [7:0] CNT_END   = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] SCORE_END = 8'(SCORE_DIV - 1);
  localparam logic [7:0] HIT_END   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] FLASH_END = 8'(FLASH_DIV - 1);
  localparam logic [3:0] SPD_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0] SPD_MAX   = 4'(SPEED_MAX);
  state_t      r_state;
  logic        r_run, r_clr, r_blink, r_hit_latch;
  logic [3:0]  r_speed;
  logic [15:0] r_score, r_hiscore;
  logic [7:0]  r_fcnt;
  logic        w_hit, w_sat;
  logic [15:0] w_inc;
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic c;
    bcd_inc = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        bcd_inc[4*i +: 4] = (s[4*i +: 4] == 4'd9) ? 4'd0 : s[4*i +: 4] + 4'd1;
        c = (s[4*i +: 4] == 4'd9);
      end
  endfunction
  assign w_hit = r_hit_latch | bus.hit;
  assign w_sat = (r_score == 16'h9999);
  assign w_inc = bcd_inc(r_score);
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_run       <= 1'b0;
      r_clr       <= 1'b0;
      r_blink     <= 1'b0;
      r_hit_latch <= 1'b0;
      r_speed     <= SPD_INIT;
      r_score     <= 16'h0;
      r_hiscore   <= 16'h0;
      r_fcnt      <= 8'd0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        IDLE, OVER:
          if (bus.start) begin
            r_state <= COUNT;
            r_clr   <= 1'b1;
            r_score <= 16'h0;
            r_speed <= SPD_INIT;
            r_fcnt  <= 8'd0;
            r_blink <= 1'b0;
          end else if (r_state == OVER && bus.frame) begin
            r_fcnt  <= (r_fcnt == FLASH_END) ? 8'd0 : r_fcnt + 8'd1;
            r_blink <= (r_fcnt == FLASH_END) ? ~r_blink : r_blink;
          end
        COUNT:
          if (bus.frame) begin
            r_state <= (r_fcnt == CNT_END) ? PLAY : COUNT;
            r_run   <= (r_fcnt == CNT_END);
            r_fcnt  <= (r_fcnt == CNT_END) ? 8'd0 : r_fcnt + 8'd1;
          end
        PLAY:
          if (bus.pause) begin
            r_state     <= PAUSE;
            r_run       <= 1'b0;
            r_hit_latch <= 1'b0;
          end else if (bus.frame) begin
            r_hit_latch <= 1'b0;
            if (w_hit) begin
              r_state <= HIT;
              r_run   <= 1'b0;
              r_fcnt  <= 8'd0;
            end else if (r_fcnt == SCORE_END) begin
              r_fcnt <= 8'd0;
              // a saturated score never rolls over, so speed only moves on a real increment
              if (!w_sat) begin
                r_score <= w_inc;
                if (r_score[7:0] == 8'h99 && r_speed < SPD_MAX) r_speed <= r_speed + 4'd1;
              end
            end else r_fcnt <= r_fcnt + 8'd1;
          end else r_hit_latch <= w_hit;
        PAUSE:
          if (bus.pause) begin
            r_state <= PLAY;
            r_run   <= 1'b1;
          end
        HIT:
          if (bus.frame) begin
            if (r_fcnt == HIT_END) begin
              r_state <= OVER;
              r_fcnt  <= 8'd0;
              r_blink <= 1'b1;
              if (r_score > r_hiscore) r_hiscore <= r_score;
            end else r_fcnt <= r_fcnt + 8'd1;
          end
        default: begin
          r_state <= IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end
  assign bus.state   = r_state;
  assign bus.run     = r_run;
  assign bus.speed   = r_speed;
  assign bus.clr     = r_clr;
  assign bus.score   = r_score;
  assign bus.hiscore = r_hiscore;
  assign bus.blink   = r_blink;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed table and sequence checks of game_sequencer with shortened timing parameters
module tb_game_sequencer;
  logic board_clk = 1'b0;
  logic Reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  game_sequencer_if bus ();
  game_sequencer #(
    .COUNT_FRAMES(5), .SCORE_DIV(2), .HIT_FRAMES(3),
    .SPEED_INIT(1), .SPEED_MAX(8), .FLASH_DIV(3)
  ) dut (
    .board_clk(board_clk),
    .Reset(Reset),
    .bus(bus)
  );
  always #5 board_clk = ~board_clk;
  typedef struct packed {
    logic        f, s, p, h;
    logic [3:0]  st;
    logic        run;
    logic        clr;
    logic [15:0] score;
    logic [3:0]  speed;
  } vec_t;
  vec_t vec [28];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input logic f, input logic s, input logic p, input logic h);
    bus.frame = f;
    bus.start = s;
    bus.pause = p;
    bus.hit   = h;
    @(negedge board_clk);
    bus.frame = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = 1'b0;
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, " state"}, 16'(bus.state), 16'h0);
    check({tag, " run"}, 16'(bus.run), 16'h0);
    check({tag, " clr"}, 16'(bus.clr), 16'h0);
    check({tag, " score"}, bus.score, 16'h0);
    check({tag, " hiscore"}, bus.hiscore, 16'h0);
    check({tag, " speed"}, 16'(bus.speed), 16'h1);
    check({tag, " blink"}, 16'(bus.blink), 16'h0);
  endtask
  initial begin
    bus.frame = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit   = 1'b0;
    vec[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 16'h0000, 4'd1};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'h0000, 4'd1};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0000, 4'd1};
    vec[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0000, 4'd1};
    vec[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0001, 4'd1};
    vec[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0001, 4'd1};
    vec[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0002, 4'd1};
    vec[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0002, 4'd1};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0002, 4'd1};
    vec[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0002, 4'd1};
    vec[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 16'h0002, 4'd1};
    vec[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0002, 4'd1};
    vec[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0002, 4'd1};
    vec[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0003, 4'd1};
    vec[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 16'h0003, 4'd1};
    vec[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 16'h0003, 4'd1};
    vec[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0003, 4'd1};
    vec[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0003, 4'd1};
    vec[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 16'h0003, 4'd1};
    vec[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 16'h0003, 4'd1};
    vec[27] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0003, 4'd1};
    repeat (2) @(negedge board_clk);
    check_reset("reset");
    Reset = 1'b0;
    @(negedge board_clk);
    for (int i = 0; i < 28; i++) begin
      step(vec[i].f, vec[i].s, vec[i].p, vec[i].h);
      check($sformatf("v%0d state", i), 16'(bus.state), 16'(vec[i].st));
      check($sformatf("v%0d run", i), 16'(bus.run), 16'(vec[i].run));
      check($sformatf("v%0d clr", i), 16'(bus.clr), 16'(vec[i].clr));
      check($sformatf("v%0d score", i), bus.score, vec[i].score);
      check($sformatf("v%0d speed", i), 16'(bus.speed), 16'(vec[i].speed));
    end
    check("over hiscore", bus.hiscore, 16'h0003);
    check("over blink", 16'(bus.blink), 16'h1);
    frames(2);
    check("blink hold", 16'(bus.blink), 16'h1);
    frames(1);
    check("blink toggle", 16'(bus.blink), 16'h0);
    frames(3);
    check("blink toggle2", 16'(bus.blink), 16'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart state", 16'(bus.state), 16'h1);
    check("restart clr", 16'(bus.clr), 16'h1);
    check("restart score", bus.score, 16'h0);
    check("restart blink", 16'(bus.blink), 16'h0);
    check("restart hiscore", bus.hiscore, 16'h0003);
    frames(4);
    check("count not done", 16'(bus.state), 16'h1);
    frames(1);
    check("play again", 16'(bus.state), 16'h2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("hit with frame", 16'(bus.state), 16'h4);
    frames(3);
    check("over2 state", 16'(bus.state), 16'h5);
    check("hiscore kept", bus.hiscore, 16'h0003);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frames(5);
    check("long play", 16'(bus.state), 16'h2);
    frames(198);
    check("score 99", bus.score, 16'h0099);
    check("speed pre", 16'(bus.speed), 16'h1);
    frames(2);
    check("score 100", bus.score, 16'h0100);
    check("speed 2", 16'(bus.speed), 16'h2);
    frames(19798);
    check("score 9999", bus.score, 16'h9999);
    check("speed sat", 16'(bus.speed), 16'h8);
    frames(12);
    check("score sat", bus.score, 16'h9999);
    check("speed sat2", 16'(bus.speed), 16'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    frames(1);
    check("hit2 state", 16'(bus.state), 16'h4);
    frames(3);
    check("over3 state", 16'(bus.state), 16'h5);
    check("hiscore max", bus.hiscore, 16'h9999);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frames(2);
    check("mid count", 16'(bus.state), 16'h1);
    #2 Reset = 1'b1;
    #1 check_reset("async");
    @(negedge board_clk);
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset("post");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level play controller for the ducking-duck game. It turns button pulses, the per-frame tick and the duck/obstacle overlap signal into the game `state`, a scroll-enable and speed for `level`, and one-cycle clear pulses. It also keeps the BCD score and high score, which `vga_bitchange` and the seven-segment path display. It sits between the debouncers, `display_controller`, `core` and `level`, and replaces ad-hoc state logic in those blocks.

## Interface

Parameters:
- `COUNT_FRAMES`, 180: length of the pre-play countdown, in frames.
- `SCORE_DIV`, 6: frames per score point.
- `HIT_FRAMES`, 60: length of the hit freeze before game over, in frames.
- `SPEED_INIT`, 1: scroll speed at the start of a run.
- `SPEED_MAX`, 8: speed saturation value.
- `FLASH_DIV`, 16: frames per `blink` toggle in OVER.

Ports:
- `board_clk`  in  1: system clock.
- `Reset`  in  1: asynchronous, active-high.
- `frame`  in  1: one-cycle pulse per video frame, issued at the start of vertical blanking.
- `start`  in  1: debounced single-cycle pulse (BtnU).
- `pause`  in  1: debounced single-cycle pulse (BtnR).
- `hit`  in  1: level signal; high on any pixel where duck and obstacle overlap.
- `state`  out  4: game state code.
- `run`  out  1: scroll enable for `level`.
- `speed`  out  4: scroll pixels per frame.
- `clr`  out  1: one-cycle pulse that clears the `level` and `core` positions.
- `score`  out  16: score as 4 BCD digits.
- `hiscore`  out  16: high score as 4 BCD digits.
- `blink`  out  1: blink phase for the game-over text.

## Operation

State codes: IDLE=0, COUNT=1, PLAY=2, PAUSE=3, HIT=4, OVER=5. Codes 6–15 are illegal and recover to IDLE on the next cycle. `fcnt` is an internal 8-bit frame counter.

- **IDLE**
  - `run`=0.
  - On `start`: go to COUNT. Pulse `clr`. Set `score`=0, `speed`=`SPEED_INIT`, `fcnt`=0.
- **COUNT**
  - `run`=0.
  - Each `frame` increments `fcnt`.
  - On the `frame` where `fcnt`==`COUNT_FRAMES`-1: go to PLAY and set `fcnt`=0.
- **PLAY**
  - `run`=1.
  - `hit_latch` is set by `hit` on any cycle.
  - On `frame` with `hit_latch` set: go to HIT, set `fcnt`=0, score unchanged. A `hit` in the same cycle as `frame` counts toward that frame.
  - On `frame` with `hit_latch` clear: increment `fcnt`. When `fcnt`==`SCORE_DIV`-1, clear `fcnt` and BCD-increment `score`.
  - `hit_latch` clears on every `frame`.
  - On `pause`: go to PAUSE. If `pause` and `frame` arrive in the same cycle, `pause` wins and the frame is ignored.
- **PAUSE**
  - `run`=0; `fcnt` and `score` are held.
  - `hit` is ignored and `hit_latch` is held at 0.
  - On `pause`: go back to PLAY. `start` is ignored.
- **HIT**
  - `run`=0.
  - Each `frame` increments `fcnt`.
  - At `fcnt`==`HIT_FRAMES`-1 on `frame`: go to OVER. If `score`>`hiscore`, load `hiscore` with `score` on the same edge. Set `fcnt`=0 and `blink`=1.
- **OVER**
  - `run`=0.
  - `blink` toggles every `FLASH_DIV` frames.
  - On `start`: go to COUNT with the same actions as IDLE+`start`. `blink` returns to 0.

Score and speed rules:
- BCD increment: each digit wraps 9→0 with a carry into the next digit.
- Score saturates at 9999: at 9999 the increment is suppressed.
- Speed: on every increment where the low two digits roll 99→00, `speed` increases by 1, saturating at `SPEED_MAX`.
- `pause` and `hit` are ignored in every state other than those listed above.
- `start` is ignored in COUNT, PLAY, PAUSE and HIT.

## Timing

- All outputs are registered.
  - `state`, `run` and `clr` change on the edge after the accepting `start`, `pause` or `frame` cycle (1-cycle latency).
  - `clr` is high for exactly one cycle, coincident with the first COUNT cycle.
  - `score` and `speed` update on the edge after `frame`.
- Reset values: `state`=IDLE, `run`=0, `speed`=`SPEED_INIT`, `clr`=0, `score`=0, `hiscore`=0, `blink`=0, `fcnt`=0, `hit_latch`=0.
- `hiscore` is cleared only by `Reset`.
- Reset mid-run forces all of the above immediately (asynchronous); no `clr` pulse is generated.
- `start` and `frame` in the same cycle while in IDLE or OVER: `start` is accepted, and the frame is not counted toward COUNT.

## Test plan

- Reset, then `start`, then 180 `frame` pulses → `clr` high for 1 cycle after `start`; `state`=1 until the 180th frame; `state`=2 one cycle after it; `run`=1.
- In PLAY, 600 frames with no `hit` → `score`=16'h0100; `speed`=2 on the edge after the 600th frame.
- In PLAY, single-cycle `hit` mid-frame, then 60 frames → `state`=4 after the next `frame`; `state`=5 after the 60th frame; `hiscore`=`score`; `blink`=1.
- In PLAY, `pause` coincident with `frame` → `state`=3, `score` unchanged; `hit` while paused has no effect; a second `pause` → `state`=2.
- Preload `score`=16'h9999 in PLAY, 12 frames → `score` stays 9999; `speed` does not exceed 8 across a long run.
- In OVER, `start` → `state`=1, `score`=0, `hiscore` retained; assert `Reset` mid-COUNT → all outputs at reset values, `hiscore`=0.
